// File: rtl/v_pkg.sv
// Shared types for the update-issue slice: update-bus field types and the packed
// update bundle carried through the command FIFO.
package v_pkg;

   localparam int unsigned ID_W   = 8;
   localparam int unsigned KEY_W  = 16;
   localparam int unsigned SIZE_W = 12;

   typedef logic [ID_W-1:0]   id_t;
   typedef logic [KEY_W-1:0]  key_t;
   typedef logic [SIZE_W-1:0] size_t;

   typedef enum logic [1:0] {
      CMD_ADD = 2'd0,
      CMD_DEL = 2'd1,
      CMD_MOD = 2'd2,
      CMD_QRY = 2'd3
   } cmd_t;

   typedef struct packed {
      id_t   prod_id;
      cmd_t  cmd;
      key_t  key;
      size_t size;
   } upd_t;

   function automatic upd_t pack_upd(input id_t prod_id, input cmd_t cmd,
                                     input key_t key, input size_t size);
      upd_t u;
      u.prod_id = prod_id;
      u.cmd     = cmd;
      u.key     = key;
      u.size    = size;
      return u;
   endfunction

endpackage

// File: rtl/v_upd_issue_if.sv
// Command ingress / update-bus egress bundle for v_upd_issue.
// master drives commands and observes the update bus; slave is the issue block.
interface v_upd_issue_if;
   import v_pkg::*;

   logic  i_cmd_vld;
   id_t   i_cmd_prod_id;
   cmd_t  i_cmd_cmd;
   key_t  i_cmd_key;
   size_t i_cmd_size;
   logic  o_cmd_rdy;

   logic  o_upd_vld_r;
   id_t   o_upd_prod_id_r;
   cmd_t  o_upd_cmd_r;
   key_t  o_upd_key_r;
   size_t o_upd_size_r;
   logic  o_busy;

   modport master (
      output i_cmd_vld, i_cmd_prod_id, i_cmd_cmd, i_cmd_key, i_cmd_size,
      input  o_cmd_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r,
             o_upd_key_r, o_upd_size_r, o_busy
   );

   modport slave (
      input  i_cmd_vld, i_cmd_prod_id, i_cmd_cmd, i_cmd_key, i_cmd_size,
      output o_cmd_rdy, o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r,
             o_upd_key_r, o_upd_size_r, o_busy
   );

endinterface

// File: rtl/v_upd_sb.sv
// In-flight scoreboard: a HAZ_WINDOW-deep shift of issued prod_ids; the FIFO head
// is blocked while its id matches any valid stage.
module v_upd_sb
   import v_pkg::*;
#(
   parameter int HAZ_WINDOW = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_issue,
   input  id_t  i_id,
   input  id_t  i_head_id,
   output logic o_blocked,
   output logic o_any_vld
);

   logic [HAZ_WINDOW-1:0] r_vld;
   id_t                   r_id [HAZ_WINDOW];
   logic                  w_blocked;

   // valid bits shift every cycle and are the only reset state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= i_issue;
         for (int i = 1; i < HAZ_WINDOW; i++) begin
            r_vld[i] <= r_vld[i-1];
         end
      end
   end

   // id stages shift alongside; contents are don't-care while invalid
   always_ff @(posedge clk) begin
      r_id[0] <= i_id;
      for (int i = 1; i < HAZ_WINDOW; i++) begin
         r_id[i] <= r_id[i-1];
      end
   end

   // match head id against every valid in-flight stage
   always_comb begin
      w_blocked = 1'b0;
      for (int i = 0; i < HAZ_WINDOW; i++) begin
         w_blocked = w_blocked | (r_vld[i] & (r_id[i] == i_head_id));
      end
   end

   assign o_blocked = w_blocked;
   assign o_any_vld = |r_vld;

endmodule

// File: rtl/v_upd_issue.sv
// Update issue block: command FIFO feeding a registered update bus, with optional
// same-id hazard blocking enabled by macro V_UPD_HAZARD_EN.
module v_upd_issue
   import v_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int HAZ_WINDOW = 3
) (
   input  logic         clk,
   input  logic         rst,
   v_upd_issue_if.slave bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] C_EMPTY = {CW{1'b0}};

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HAZ_WINDOW < 1) begin : g_bad_param
      $error("v_upd_issue: DEPTH must be a power of two >= 2 and HAZ_WINDOW >= 1");
   end

   upd_t          r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_upd_vld;
   upd_t          r_upd;

   upd_t w_in;
   upd_t w_head;
   logic w_rdy;
   logic w_push;
   logic w_pop;
   logic w_blocked;
   logic w_sb_any;

   assign w_in   = pack_upd(bus.i_cmd_prod_id, bus.i_cmd_cmd, bus.i_cmd_key, bus.i_cmd_size);
   assign w_head = r_mem[r_rd_ptr];
   assign w_rdy  = (r_count != C_FULL);
   assign w_push = bus.i_cmd_vld & w_rdy;
   // no enqueue bypass: only a command already stored can issue
   assign w_pop  = (r_count != C_EMPTY) & ~w_blocked;

`ifdef V_UPD_HAZARD_EN
   v_upd_sb #(
      .HAZ_WINDOW (HAZ_WINDOW)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .i_issue   (w_pop),
      .i_id      (w_head.prod_id),
      .i_head_id (w_head.prod_id),
      .o_blocked (w_blocked),
      .o_any_vld (w_sb_any)
   );
`else
   assign w_blocked = 1'b0;
   assign w_sb_any  = 1'b0;
`endif

   // FIFO storage write; storage is intentionally not reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_in;
      end
   end

   // pointers, occupancy and bus valid
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= {PW{1'b0}};
         r_rd_ptr  <= {PW{1'b0}};
         r_count   <= C_EMPTY;
         r_upd_vld <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_upd_vld <= w_pop;
      end
   end

   // update payload loads only on issue and holds otherwise
   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_upd <= w_head;
      end else begin
         r_upd <= r_upd;
      end
   end

   assign bus.o_cmd_rdy       = w_rdy;
   assign bus.o_upd_vld_r     = r_upd_vld;
   assign bus.o_upd_prod_id_r = r_upd.prod_id;
   assign bus.o_upd_cmd_r     = r_upd.cmd;
   assign bus.o_upd_key_r     = r_upd.key;
   assign bus.o_upd_size_r    = r_upd.size;
   assign bus.o_busy          = (r_count != C_EMPTY) | w_sb_any;

endmodule

// File: tb/tb_v_upd_issue.sv
// Scoreboard bench for v_upd_issue: expected update-bus events (payload + cycle)
// are queued at drive time and matched against observed pulses.
module tb_v_upd_issue;
   import v_pkg::*;

   localparam int HW = 3;

   typedef struct {
      upd_t p;
      int   cyc;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   ev_t  exp_q[$];
   ev_t  obs_q[$];

   v_upd_issue_if bus();

   v_upd_issue #(.DEPTH(4), .HAZ_WINDOW(HW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.o_upd_vld_r === 1'b1) begin
         ev_t e;
         e.p.prod_id = bus.o_upd_prod_id_r;
         e.p.cmd     = bus.o_upd_cmd_r;
         e.p.key     = bus.o_upd_key_r;
         e.p.size    = bus.o_upd_size_r;
         e.cyc       = cyc;
         obs_q.push_back(e);
      end
   end

   function automatic upd_t mk(input id_t id);
      upd_t u;
      u.prod_id = id;
      u.cmd     = cmd_t'(id[1:0]);
      u.key     = {id, ~id};
      u.size    = {id, 4'h3};
      return u;
   endfunction

   task automatic drive(input logic v, input id_t id);
      upd_t p;
      p = mk(id);
      @(posedge clk);
      #1;
      bus.i_cmd_vld     = v;
      bus.i_cmd_prod_id = p.prod_id;
      bus.i_cmd_cmd     = p.cmd;
      bus.i_cmd_key     = p.key;
      bus.i_cmd_size    = p.size;
   endtask

   task automatic expect_at(input id_t id, input int at);
      ev_t e;
      e.p   = mk(id);
      e.cyc = at;
      exp_q.push_back(e);
   endtask

   task automatic settle();
      int n = 0;
      while (obs_q.size() < exp_q.size() && n < 80) begin
         @(negedge clk);
         n++;
      end
      repeat (HW + 6) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_cmd_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_chk++;
      if (bus.o_cmd_rdy !== 1'b1) begin
         n_fail++; $display("FAIL reset_rdy: got %b, expected 1", bus.o_cmd_rdy);
      end
      n_chk++;
      if (bus.o_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b, expected 0", bus.o_busy);
      end
      n_chk++;
      if (bus.o_upd_vld_r !== 1'b0) begin
         n_fail++; $display("FAIL reset_vld: got %b, expected 0", bus.o_upd_vld_r);
      end
   endtask

   task automatic test_single();
      int k;
      int low_at;
      drive(1'b1, 8'd5);
      k = cyc;
      expect_at(8'd5, k + 2);
`ifdef V_UPD_HAZARD_EN
      low_at = k + 2 + HW;
`else
      low_at = k + 2;
`endif
      drive(1'b0, 8'd0);
      @(negedge clk);
      while (cyc < low_at - 1) @(negedge clk);
      n_chk++;
      if (bus.o_busy !== 1'b1) begin
         n_fail++; $display("FAIL single_busy_hi: got %b at cyc %0d, expected 1", bus.o_busy, cyc);
      end
      @(negedge clk);
      n_chk++;
      if (bus.o_busy !== 1'b0) begin
         n_fail++; $display("FAIL single_busy_lo: got %b at cyc %0d, expected 0", bus.o_busy, cyc);
      end
      settle();
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL single_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_chk++;
         if (o.p !== e.p || o.cyc != e.cyc) begin
            n_fail++;
            $display("FAIL single_evt: got id=%0d cmd=%0d key=%h size=%h @%0d, expected id=%0d cmd=%0d key=%h size=%h @%0d",
                     o.p.prod_id, o.p.cmd, o.p.key, o.p.size, o.cyc, e.p.prod_id, e.p.cmd, e.p.key, e.p.size, e.cyc);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, id_t'(i));
         expect_at(id_t'(i), cyc + 2);
      end
      drive(1'b0, 8'd0);
      settle();
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL b2b_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_chk++;
         if (o.p !== e.p || o.cyc != e.cyc) begin
            n_fail++;
            $display("FAIL b2b_evt: got id=%0d key=%h @%0d, expected id=%0d key=%h @%0d",
                     o.p.prod_id, o.p.key, o.cyc, e.p.prod_id, e.p.key, e.cyc);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_same_id();
      int k;
      drive(1'b1, 8'd7);
      k = cyc;
      expect_at(8'd7, k + 2);
`ifdef V_UPD_HAZARD_EN
      drive(1'b1, 8'd7);
      expect_at(8'd7, k + 3 + HW);
      drive(1'b1, 8'd8);
      expect_at(8'd8, k + 4 + HW);
`else
      drive(1'b1, 8'd7);
      expect_at(8'd7, k + 3);
      drive(1'b1, 8'd7);
      expect_at(8'd7, k + 4);
`endif
      drive(1'b0, 8'd0);
      settle();
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL same_id_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_chk++;
         if (o.p !== e.p || o.cyc != e.cyc) begin
            n_fail++;
            $display("FAIL same_id_evt: got id=%0d @%0d, expected id=%0d @%0d",
                     o.p.prod_id, o.cyc, e.p.prod_id, e.cyc);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

`ifdef V_UPD_HAZARD_EN
   task automatic test_full();
      int k;
      drive(1'b1, 8'd7);
      k = cyc;
      expect_at(8'd7, k + 2);
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 8'd7);
         expect_at(8'd7, k + 2 + i * (HW + 1));
      end
      n_chk++;
      if (bus.o_cmd_rdy !== 1'b1) begin
         n_fail++; $display("FAIL full_rdy_cnt3: got %b, expected 1", bus.o_cmd_rdy);
      end
      drive(1'b1, 8'd9);
      n_chk++;
      if (bus.o_cmd_rdy !== 1'b0) begin
         n_fail++; $display("FAIL full_rdy_cnt4: got %b, expected 0", bus.o_cmd_rdy);
      end
      drive(1'b1, 8'd9);
      n_chk++;
      if (bus.o_cmd_rdy !== 1'b1) begin
         n_fail++; $display("FAIL full_rdy_after_pop: got %b, expected 1", bus.o_cmd_rdy);
      end
      expect_at(8'd9, k + 3 + 4 * (HW + 1));
      drive(1'b0, 8'd0);
      settle();
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL full_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_chk++;
         if (o.p !== e.p || o.cyc != e.cyc) begin
            n_fail++;
            $display("FAIL full_evt: got id=%0d @%0d, expected id=%0d @%0d",
                     o.p.prod_id, o.cyc, e.p.prod_id, e.cyc);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask
`endif

   task automatic test_reset_mid();
      int k;
      drive(1'b1, 8'd7);
      k = cyc;
`ifdef V_UPD_HAZARD_EN
      expect_at(8'd7, k + 2);
      for (int i = 0; i < 3; i++) drive(1'b1, 8'd7);
`else
      drive(1'b1, 8'd3);
`endif
      rst = 1'b1;
      drive(1'b0, 8'd0);
      rst = 1'b0;
      n_chk++;
      if (bus.o_cmd_rdy !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_rdy: got %b, expected 1", bus.o_cmd_rdy);
      end
      n_chk++;
      if (bus.o_busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_busy: got %b, expected 0", bus.o_busy);
      end
      n_chk++;
      if (bus.o_upd_vld_r !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_vld: got %b, expected 0", bus.o_upd_vld_r);
      end
      settle();
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rst_mid_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_chk++;
         if (o.p !== e.p || o.cyc != e.cyc) begin
            n_fail++;
            $display("FAIL rst_mid_evt: got id=%0d @%0d, expected id=%0d @%0d",
                     o.p.prod_id, o.cyc, e.p.prod_id, e.cyc);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst               = 1'b1;
      bus.i_cmd_vld     = 1'b0;
      bus.i_cmd_prod_id = '0;
      bus.i_cmd_cmd     = CMD_ADD;
      bus.i_cmd_key     = '0;
      bus.i_cmd_size    = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_same_id();
`ifdef V_UPD_HAZARD_EN
      test_full();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/v_upd_issue.md
V_UPD_ISSUE -- requirements
Module: v_upd_issue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter HAZ_WINDOW, default 3, cycles an issued prod_id stays in flight downstream.
REQ-003 The block SHALL have port clk, input, 1, clock; all state on posedge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port i_cmd_vld, input, 1, ingress command valid.
REQ-006 The block SHALL have ports i_cmd_prod_id / i_cmd_cmd / i_cmd_key / i_cmd_size, input, v_pkg::id_t / cmd_t / key_t / size_t, ingress payload.
REQ-007 The block SHALL have port o_cmd_rdy, output, 1, ingress ready.
REQ-008 The block SHALL have port o_upd_vld_r, output, 1, registered update-bus valid to the update pipe.
REQ-009 The block SHALL have ports o_upd_prod_id_r / o_upd_cmd_r / o_upd_key_r / o_upd_size_r, output, id_t / cmd_t / key_t / size_t, registered update-bus payload.
REQ-010 The block SHALL have port o_busy, output, 1, FIFO non-empty or any id in flight.

Function
REQ-011 A command SHALL be accepted on a cycle with i_cmd_vld && o_cmd_rdy and stored in FIFO order.
REQ-012 o_cmd_rdy SHALL equal (count != DEPTH), derived from registered state only, independent of i_cmd_vld and of same-cycle pop.
REQ-013 Count SHALL track 0..DEPTH; push+pop in one cycle leaves count unchanged; read/write pointers wrap modulo DEPTH.
REQ-014 Issue SHALL occur in a cycle when FIFO is non-empty and head is not hazard-blocked; issue pops the head.
REQ-015 On issue in cycle t, o_upd_vld_r SHALL be 1 in cycle t+1 for exactly one cycle with head payload; else 0.
REQ-016 Payload registers SHALL load only on issue and hold otherwise.
REQ-017 Minimum latency SHALL be 2 cycles: accepted in cycle t into empty FIFO, issued in t+1, o_upd_vld_r high in t+2; no enqueue bypass.
REQ-018 Scoreboard: HAZ_WINDOW-deep shift register of {vld,id}; stage 0 loads {issue, head id} each cycle; stages shift every cycle.
REQ-019 Head SHALL be blocked when any valid scoreboard stage id equals head prod_id.
REQ-020 Same-id commands SHALL therefore be separated by exactly HAZ_WINDOW idle bus cycles when otherwise back-to-back; different ids issue back-to-back.
REQ-021 Blocking SHALL be in-order: a blocked head stalls all younger entries (no reordering).
REQ-022 o_busy SHALL be (count != 0) || any scoreboard vld.

Reset
REQ-023 rst SHALL clear count, pointers, scoreboard vld bits and o_upd_vld_r; o_cmd_rdy=1, o_busy=0 in the cycle after reset.
REQ-024 Payload and FIFO storage SHALL not be reset.
REQ-025 rst asserted mid-operation SHALL discard all queued and in-flight commands; no o_upd_vld_r pulse follows reset.

Configuration
REQ-026 Macro V_UPD_HAZARD_EN defined: scoreboard and blocking per REQ-018..021 SHALL be present.
REQ-027 Macro V_UPD_HAZARD_EN undefined: scoreboard SHALL be omitted, head never blocked, o_busy = (count != 0), HAZ_WINDOW ignored.

Structure
REQ-028 id_t, cmd_t, key_t, size_t and a packed upd_t bundle {prod_id,cmd,key,size} SHALL live in v_pkg.
REQ-029 The scoreboard SHALL be sub-module v_upd_sb (params HAZ_WINDOW; ports issue, id, head id, blocked, any_vld).

Verification
REQ-030 Single cmd id=5 into empty block -> o_upd_vld_r high exactly in cycle t+2, payload matches, o_busy low HAZ_WINDOW+1 cycles after issue completes.
REQ-031 Ids 1,2,3,4 back-to-back -> four consecutive o_upd_vld_r cycles, in order.
REQ-032 Ids 7,7 back-to-back (hazard on, HAZ_WINDOW=3) -> second pulse 4 cycles after first; with 7,7,8 -> 8 follows second 7 (no reorder).
REQ-033 Hold output stalled via repeated id, push DEPTH=4 cmds -> o_cmd_rdy drops at count 4; push+pop at full with i_cmd_vld high -> no accept that cycle.
REQ-034 rst asserted with 3 queued and 1 in flight -> no further o_upd_vld_r, o_cmd_rdy=1, o_busy=0 next cycle.
REQ-035 Macro undefined, ids 7,7,7 -> three consecutive o_upd_vld_r cycles.
